apb_lb_bridge: RTL and testbench

APB_LB_BRIDGE -- requirements
Module: apb_lb_bridge

---
 rtl/apb_lb_pkg.sv | 14 +
 rtl/apb_lb_bridge.sv | 138 +++++++++++++
 tb/tb_apb_lb_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_lb_pkg.sv
// Shared definitions for the APB to local-bus bridge: FSM state encoding and
// the read value returned when a local-bus access times out.
package apb_lb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_lb_bridge.sv
// APB completer that forwards each access to a simple local bus and returns a
// registered pready/prdata/pslverr. Define APB_LB_BRIDGE_TIMEOUT_EN to bound local-bus waits.
module apb_lb_bridge
  import apb_lb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr,
  output logic [ADDR_W-1:0]     lb_waddr,
  output logic [DATA_W-1:0]     lb_wdata,
  output logic [DATA_W/8-1:0]   lb_wstrb,
  output logic                  lb_wen,
  input  logic                  lb_wready,
  output logic [ADDR_W-1:0]     lb_raddr,
  output logic                  lb_ren,
  input  logic [DATA_W-1:0]     lb_rdata,
  input  logic                  lb_rvalid
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state, state_nx;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;
  logic              pready_q;
  logic [DATA_W-1:0] prdata_q;

  // APB holds address/data stable for the whole access, so no local copies are kept.
  assign lb_waddr = paddr;
  assign lb_raddr = paddr;
  assign lb_wdata = pwdata;
  assign lb_wstrb = pstrb;

`ifdef APB_LB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             err_set;
  logic             pslverr_q;

  // Counts cycles spent in WR/RD; timeout flags the last permitted wait cycle.
  always_ff @(posedge clk) begin
    if (rst || (state != WR && state != RD)) wait_cnt <= '0;
    else                                     wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) pslverr_q <= 1'b0;
    else     pslverr_q <= err_set;
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lb_wen   = 1'b0;
    lb_ren   = 1'b0;
    cap_en   = 1'b0;
    cap_data = lb_rdata;
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
    err_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (psel && penable) state_nx = pwrite ? WR : RD;
      end
      WR: begin
        lb_wen = 1'b1;
        if (!psel)          state_nx = IDLE;
        else if (lb_wready) state_nx = DONE;
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
        else if (timeout) begin
          state_nx = DONE;
          err_set  = 1'b1;
        end
`endif
      end
      RD: begin
        lb_ren = 1'b1;
        if (!psel) state_nx = IDLE;
        else if (lb_rvalid) begin
          state_nx = DONE;
          cap_en   = 1'b1;
        end
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
        else if (timeout) begin
          state_nx = DONE;
          err_set  = 1'b1;
          cap_en   = 1'b1;
          cap_data = DATA_W'(ERR_RDATA);
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // pready is high exactly for the DONE cycle; prdata only changes on read completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= (state_nx == DONE);
      if (cap_en) prdata_q <= cap_data;
    end
  end

  assign pready = pready_q;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_lb_bridge.sv
// Randomized bench for apb_lb_bridge: the bench acts as APB requester and local-bus
// slave, and predicts latency, enables and data from a transaction-level model.
module tb_apb_lb_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int TO     = 16;
  localparam int NEVER  = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready, pslverr;
  logic [DATA_W-1:0] prdata;
  logic [ADDR_W-1:0] lb_waddr, lb_raddr;
  logic [DATA_W-1:0] lb_wdata, lb_rdata;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen, lb_wready, lb_ren, lb_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];
  logic [31:0] exp_prdata;

  always #5 clk = ~clk;

  apb_lb_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb),
    .lb_wen(lb_wen), .lb_wready(lb_wready),
    .lb_raddr(lb_raddr), .lb_ren(lb_ren),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
  );

  // Local-bus slave storage, written only through what the bridge presents.
  assign lb_rdata = lb_rvalid ? slv_mem[lb_raddr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (lb_wen && lb_wready) begin
      for (int b = 0; b < STRB_W; b++)
        if (lb_wstrb[b]) slv_mem[lb_waddr[7:2]][8*b +: 8] <= lb_wdata[8*b +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One APB transfer; dly = local-bus wait cycles before ready/valid (NEVER = no response).
  task automatic xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly);
    int  lat_exp, en_exp, got, en_cnt;
    bit  to, bad;
    to = 1'b0;
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
    to = (dly >= TO);
`endif
    lat_exp = to ? TO + 1 : dly + 2;
    en_exp  = to ? TO : dly + 1;
    got = 0; en_cnt = 0; bad = 1'b0;

    @(negedge clk);
    check_eq("pready_low_before_access", pready, 0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    lb_wready = 1'b0; lb_rvalid = 1'b0;
    @(negedge clk);
    penable = 1'b1;

    for (int cyc = 1; cyc <= lat_exp + 3 && got == 0; cyc++) begin
      @(negedge clk);
      if (wr ? lb_wen : lb_ren) en_cnt++;
      if (wr ? lb_ren : lb_wen) bad = 1'b1;
      if (wr && lb_wen && (lb_waddr !== a || lb_wdata !== d || lb_wstrb !== s)) bad = 1'b1;
      if (!wr && lb_ren && lb_raddr !== a) bad = 1'b1;
      if (pready) got = cyc;
      lb_wready = wr  && (got == 0) && (cyc - 1 == dly);
      lb_rvalid = !wr && (got == 0) && (cyc - 1 == dly);
    end
    lb_wready = 1'b0; lb_rvalid = 1'b0;

    check_eq(wr ? "wr_pready_latency" : "rd_pready_latency", got, lat_exp);
    check_eq(wr ? "lb_wen_cycles" : "lb_ren_cycles", en_cnt, en_exp);
    check_eq("lb_side_signals", bad, 0);
    check_eq("pslverr", pslverr, to);
    if (wr) begin
      check_eq("prdata_held_on_write", prdata, exp_prdata);
      if (!to) ref_mem[a[7:2]] = merge_strb(ref_mem[a[7:2]], d, s);
    end else begin
      exp_prdata = to ? 32'hDEADBEEF : ref_mem[a[7:2]];
      check_eq("rd_prdata", prdata, exp_prdata);
    end
  endtask

  initial begin
    int dly, hits;
    bit wr;
    logic [5:0] idx;

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 32'h00020023;
    slv_mem[16] = 32'h00020023;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; lb_wready = 1'b0; lb_rvalid = 1'b0;
    exp_prdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_pready", pready, 0);
    check_eq("rst_pslverr", pslverr, 0);
    check_eq("rst_prdata", prdata, 0);
    check_eq("rst_lb_wen", lb_wen, 0);
    check_eq("rst_lb_ren", lb_ren, 0);
    rst = 1'b0;

    xfer(1'b1, 12'h000, 32'h12345678, 4'hF, 0);
    xfer(1'b0, 12'h040, 32'h0, 4'h0, 1);
    xfer(1'b1, 12'h010, 32'hA5C3_0F96, 4'hF, 5);
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 2);
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
    xfer(1'b0, 12'h080, 32'h0, 4'h0, NEVER);
    xfer(1'b0, 12'h080, 32'h0, 4'h0, 1);
    xfer(1'b1, 12'h084, 32'h0BAD_F00D, 4'hF, NEVER);
    xfer(1'b1, 12'h088, 32'h1357_9BDF, 4'h3, TO - 1);
    xfer(1'b0, 12'h088, 32'h0, 4'h0, TO - 1);
`else
    xfer(1'b0, 12'h080, 32'h0, 4'h0, 20);
`endif

    xfer(1'b1, 12'h004, 32'h00000005, 4'hF, 0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0, 0);

    for (int n = 0; n < 30; n++) begin
      wr  = $urandom_range(0, 1);
      idx = 6'($urandom_range(0, 63));
      dly = $urandom_range(0, 4);
`ifdef APB_LB_BRIDGE_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) dly = $urandom_range(TO - 2, TO + 3);
`endif
      xfer(wr, {4'h0, idx, 2'b00}, $urandom, 4'($urandom_range(1, 15)), dly);
    end

    // Requester drops psel mid-write: no pready, no further local-bus write.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h0C0; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_wen_active", lb_wen, 1);
    psel = 1'b0; penable = 1'b0;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pready || lb_wen) hits++;
    end
    check_eq("abort_no_pready_no_wen", hits, 0);

    // Reset in the middle of a read that the local bus never answers.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rd_ren_active", lb_ren, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_lb_ren", lb_ren, 0);
    check_eq("mid_rst_pready", pready, 0);
    check_eq("mid_rst_prdata", prdata, 0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    exp_prdata = 32'h0;
    xfer(1'b1, 12'h020, 32'h0000FF02, 4'hF, 2);
    xfer(1'b0, 12'h020, 32'h0, 4'h0, 1);

    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
